// File: rtl/ps2_key_event_decoder.sv
// Purpose: turns PS2 scan bytes into key events (make/break, E0 extended) and queues them for the consumer.
// Latency: an event is visible on evtValid one clk after the capture edge of its final byte.
// Backpressure: evtValid/evtReady pop; a push into a full FIFO with no pop is dropped and pulses overflow.
//
// Ports:
//   clk, rst            system clock; asynchronous active-high reset
//   code, valid         scan byte and level-valid from the PS2 receiver (one byte per rising valid)
//   evtCode/evtBreak/evtExt/evtValid, evtReady   head-of-queue event and its pop handshake
//   keyState            live held state of the four tracked keys (bit i = KEYi_CODE)
//   overflow            one-cycle pulse when an event is lost to a full queue
// Build option: define TYPEMATIC_FILTER_EN to drop auto-repeat makes of tracked keys that are already held.

// Small generic FIFO: power-of-2 depth, combinational head, zero on the head when empty.
// A push into a full FIFO is accepted only if a pop happens on the same edge; otherwise drop is raised.
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop_ok;
  logic             wr_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign wr_ok   = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ps2_key_event_decoder #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 65536,
  parameter logic [7:0] KEY0_CODE  = 8'h1D,
  parameter logic [7:0] KEY1_CODE  = 8'h1B,
  parameter logic [7:0] KEY2_CODE  = 8'h44,
  parameter logic [7:0] KEY3_CODE  = 8'h4B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       valid,
  output logic [7:0] evtCode,
  output logic       evtBreak,
  output logic       evtExt,
  output logic       evtValid,
  input  logic       evtReady,
  output logic [3:0] keyState,
  output logic       overflow
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BRK     = 2'd1;
  localparam logic [1:0] EXT     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  localparam int            TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [31:0]   KEY_CODES = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] to_cnt;
  logic          last_valid;
  logic          capture;
  logic          emit;
  evt_t          emit_evt;
  evt_t          head_evt;
  logic [3:0]    key_hit;
  logic          track;
  logic          is_repeat;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_drop;

  // valid is a level that can last several cycles; only its rising edge carries a byte.
  assign capture = valid && !last_valid;

  always_comb begin
    state_nxt     = state;
    emit          = 1'b0;
    emit_evt.code = code;
    emit_evt.brk  = (state == BRK) || (state == EXT_BRK);
    emit_evt.ext  = (state == EXT) || (state == EXT_BRK);
    if (capture) begin
      if (code == 8'h00 || code == 8'hFF) begin
        // Keyboard error/overrun: abandon any partial sequence.
        state_nxt = IDLE;
      end else if (code == 8'hF0) begin
        state_nxt = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
      end else if (code == 8'hE0) begin
        state_nxt = EXT;
      end else begin
        emit      = 1'b1;
        state_nxt = IDLE;
      end
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      // A prefix without its final byte in time is discarded silently.
      state_nxt = IDLE;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      key_hit[i] = (emit_evt.code == KEY_CODES[i*8 +: 8]);
    end
  end

  // Extended events share scan codes with ordinary keys, so they never touch keyState.
  assign track = emit && !emit_evt.ext;

`ifdef TYPEMATIC_FILTER_EN
  assign is_repeat = track && !emit_evt.brk && |(key_hit & keyState);
`else
  assign is_repeat = 1'b0;
`endif

  assign push = emit && !is_repeat;
  assign pop  = evtValid && evtReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      last_valid <= 1'b0;
      keyState   <= 4'b0000;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_valid <= valid;
      overflow   <= fifo_drop;
      if (capture || state == IDLE || to_cnt == TO_LAST) to_cnt <= '0;
      else                                               to_cnt <= to_cnt + 1'b1;
      // Held state follows the decoded stream even when the queue drops the event.
      for (int i = 0; i < 4; i++) begin
        if (track && key_hit[i]) keyState[i] <= !emit_evt.brk;
      end
    end
  end

  ps2_evt_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (emit_evt),
    .pop      (pop),
    .pop_dat  (head_evt),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  assign evtValid = !fifo_empty;
  assign evtCode  = head_evt.code;
  assign evtBreak = head_evt.brk;
  assign evtExt   = head_evt.ext;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Purpose: directed self-checking bench for ps2_key_event_decoder (table of single bytes plus corner sequences).
// Latency: checks every event one clk after its capture edge, sampling on the falling edge.
// Backpressure: exercises evtReady low/high, full-queue drop, and simultaneous push/pop at full.
module tb_ps2_key_event_decoder;
  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code = 8'h00;
  logic       valid = 1'b0;
  logic [7:0] evtCode;
  logic       evtBreak;
  logic       evtExt;
  logic       evtValid;
  logic       evtReady = 1'b1;
  logic [3:0] keyState;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ps2_key_event_decoder #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .code     (code),
    .valid    (valid),
    .evtCode  (evtCode),
    .evtBreak (evtBreak),
    .evtExt   (evtExt),
    .evtValid (evtValid),
    .evtReady (evtReady),
    .keyState (keyState),
    .overflow (overflow)
  );

  typedef struct {
    logic [7:0] b;
    logic       vld;
    logic [7:0] c;
    logic       brk;
    logic       ext;
    logic [3:0] keys;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Raise valid with a byte; returns at the falling edge right after the capture edge.
  task automatic cap(input logic [7:0] b);
    @(negedge clk);
    code  = b;
    valid = 1'b1;
    @(negedge clk);
  endtask

  // Keep valid high one more cycle (no second capture), then drop it.
  task automatic rel();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic chk_evt(input string name, input logic [7:0] c, input logic brk, input logic ext);
    chk({name, "_vld"}, 32'(evtValid), 32'd1);
    chk({name, "_code"}, 32'(evtCode), 32'(c));
    chk({name, "_brk"}, 32'(evtBreak), 32'(brk));
    chk({name, "_ext"}, 32'(evtExt), 32'(ext));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] drain_exp [4];
    int         n;

    tbl.push_back('{8'h1D, 1'b1, 8'h1D, 1'b0, 1'b0, 4'b0001});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0001});
    tbl.push_back('{8'h1D, 1'b1, 8'h1D, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 4'b0000});
    tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{8'h1D, 1'b1, 8'h1D, 1'b0, 1'b1, 4'b0000});
    tbl.push_back('{8'h44, 1'b1, 8'h44, 1'b0, 1'b0, 4'b0100});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0100});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0100});
    tbl.push_back('{8'h4B, 1'b1, 8'h4B, 1'b0, 1'b0, 4'b1100});
    tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1100});
    tbl.push_back('{8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1100});
    tbl.push_back('{8'h1B, 1'b1, 8'h1B, 1'b0, 1'b0, 4'b1110});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1110});
    tbl.push_back('{8'h44, 1'b1, 8'h44, 1'b1, 1'b0, 4'b1010});
    tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'h12, 1'b1, 8'h12, 1'b0, 1'b1, 4'b1010});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'h12, 1'b1, 8'h12, 1'b1, 1'b0, 4'b1010});
    tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b1, 4'b1010});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b1, 4'b1010});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1010});
    tbl.push_back('{8'h4B, 1'b1, 8'h4B, 1'b1, 1'b0, 4'b0010});
    tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0010});
    tbl.push_back('{8'h1B, 1'b1, 8'h1B, 1'b1, 1'b0, 4'b0000});

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(evtValid), 32'd0);
    chk("rst_code", 32'(evtCode), 32'd0);
    chk("rst_keys", 32'(keyState), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Byte table with the consumer always ready: each event lives exactly one cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      cap(tbl[i].b);
      if (tbl[i].vld) chk_evt($sformatf("tbl%0d", i), tbl[i].c, tbl[i].brk, tbl[i].ext);
      else            chk($sformatf("tbl%0d_noevt", i), 32'(evtValid), 32'd0);
      chk($sformatf("tbl%0d_keys", i), 32'(keyState), 32'(tbl[i].keys));
      rel();
      chk($sformatf("tbl%0d_after", i), 32'(evtValid), 32'd0);
    end

    // Prefix expires: the following byte is a plain make.
    cap(8'hF0);
    rel();
    repeat (TO + 4) @(negedge clk);
    chk("to_noevt", 32'(evtValid), 32'd0);
    cap(8'h1B);
    chk_evt("to_make", 8'h1B, 1'b0, 1'b0);
    chk("to_keys", 32'(keyState), 32'b0010);
    rel();

    // Prefix still live well inside the window.
    cap(8'hF0);
    rel();
    repeat (TO / 2) @(negedge clk);
    cap(8'h1B);
    chk_evt("win_brk", 8'h1B, 1'b1, 1'b0);
    chk("win_keys", 32'(keyState), 32'b0000);
    rel();

    // Fill with the consumer stalled; fifth event is dropped.
    evtReady = 1'b0;
    drain_exp = '{8'h1D, 8'h1B, 8'h44, 8'h4B};
    for (int i = 0; i < 4; i++) begin
      cap(drain_exp[i]);
      chk($sformatf("fill%0d_ovf", i), 32'(overflow), 32'd0);
      rel();
    end
    cap(8'h12);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    rel();
    chk("ovf_end", 32'(overflow), 32'd0);
    chk("ovf_keys", 32'(keyState), 32'b1111);
    evtReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_vld", i), 32'(evtValid), 32'd1);
      chk($sformatf("drain%0d_code", i), 32'(evtCode), 32'(drain_exp[i]));
      @(negedge clk);
    end
    chk("drain_empty", 32'(evtValid), 32'd0);

    // Full queue with push and pop on the same edge.
    evtReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cap(8'h12 + 8'(i));
      rel();
    end
    @(negedge clk);
    code     = 8'h16;
    valid    = 1'b1;
    evtReady = 1'b1;
    @(negedge clk);
    evtReady = 1'b0;
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(evtCode), 32'h13);
    rel();
    evtReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_drain%0d", i), 32'(evtCode), 32'h13 + 32'(i));
      @(negedge clk);
    end
    chk("pp_empty", 32'(evtValid), 32'd0);

    // Auto-repeat of a tracked key.
    cap(8'hF0);
    rel();
    cap(8'h1D);
    rel();
    chk("rep_keys0", 32'(keyState), 32'b1110);
    evtReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap(8'h1D);
      rel();
    end
    chk("rep_keys1", 32'(keyState), 32'b1111);
    n = 0;
    evtReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (!evtValid) break;
      @(negedge clk);
      n++;
    end
`ifdef TYPEMATIC_FILTER_EN
    chk("rep_count", 32'(n), 32'd1);
`else
    chk("rep_count", 32'(n), 32'd3);
`endif

    // Reset between E0 and the final byte drops the prefix.
    cap(8'hE0);
    rel();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_vld", 32'(evtValid), 32'd0);
    chk("mrst_keys", 32'(keyState), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    cap(8'h75);
    chk_evt("mrst_make", 8'h75, 1'b0, 1'b0);
    rel();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
